// File: rtl/window_shade_motor.sv
// window_shade_motor
//  Steps the shade motor one level at a time until the tracked position equals
//  the filtered requested level. A glitch filter accepts wshade only after it
//  has been steady for SETTLE_CYCLES samples. Each step drives the motor for
//  STEP_CYCLES cycles. A direction reversal passes through a motor-off dead
//  time of DEAD_CYCLES cycles.
// Ports
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  enable     in   1  1 = movement allowed; 0 = stop at the next step boundary
//  wshade     in   4  requested shade level (0 open .. 15 closed)
//  motor_up   out  1  drive motor toward level 15
//  motor_down out  1  drive motor toward level 0
//  position   out  4  tracked shade level
//  target     out  4  accepted (filtered) requested level
//  busy       out  1  1 whenever the FSM is not IDLE
//  dbg_state  out  4  one-hot FSM state {DEAD, DOWN, UP, IDLE}
module window_shade_motor #(
  parameter int STEP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEAD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] wshade,
  output logic       motor_up,
  output logic       motor_down,
  output logic [3:0] position,
  output logic [3:0] target,
  output logic       busy,
  output logic [3:0] dbg_state
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  // One-hot so each motor output is a single flop bit and cannot glitch.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_UP   = 4'b0010,
    S_DOWN = 4'b0100,
    S_DEAD = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        w_prev_q, w_prev_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]        target_q, target_d;
  logic [3:0]        position_q, position_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [3:0]        pos_new;

  // Input filter: runs in every state. Target loads on the edge where the
  // stability counter reaches its limit, i.e. after SETTLE_CYCLES equal samples.
  always_comb begin
    w_prev_d   = wshade;
    stab_cnt_d = stab_cnt_q;
    target_d   = target_q;
    if (wshade != w_prev_q) begin
      stab_cnt_d = '0;
    end else begin
      if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
      if (stab_cnt_d == STAB_MAX) target_d = wshade;
    end
  end

  // Position after the step that is completing now (saturating guard).
  always_comb begin
    pos_new = position_q;
    if (state_q == S_UP && position_q != 4'hF) pos_new = position_q + 4'd1;
    if (state_q == S_DOWN && position_q != 4'h0) pos_new = position_q - 4'd1;
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    step_cnt_d = step_cnt_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      S_IDLE: begin
        step_cnt_d = '0;
        dead_cnt_d = '0;
        if (enable && target_q > position_q)      state_d = S_UP;
        else if (enable && target_q < position_q) state_d = S_DOWN;
      end
      S_UP, S_DOWN: begin
        if (step_cnt_q == STEP_LAST) begin
          // Step boundary: the only point where target/enable are acted on.
          step_cnt_d = '0;
          position_d = pos_new;
          if (!enable || target_q == pos_new)             state_d = S_IDLE;
          else if ((target_q > pos_new) == (state_q == S_UP)) state_d = state_q;
          else                                            state_d = S_DEAD;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      S_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          dead_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        step_cnt_d = '0;
        dead_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      w_prev_q   <= '0;
      stab_cnt_q <= '0;
      target_q   <= '0;
      position_q <= '0;
      step_cnt_q <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      w_prev_q   <= w_prev_d;
      stab_cnt_q <= stab_cnt_d;
      target_q   <= target_d;
      position_q <= position_d;
      step_cnt_q <= step_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  // Outputs decoded straight from single one-hot state bits.
  always_comb begin
    motor_up   = state_q[1];
    motor_down = state_q[2];
    busy       = ~state_q[0];
    dbg_state  = state_q;
    position   = position_q;
    target     = target_q;
  end

endmodule

// File: tb/tb_window_shade_motor.sv
// Directed bench for window_shade_motor with default parameters.
module tb_window_shade_motor;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] wshade;
  logic       motor_up;
  logic       motor_down;
  logic [3:0] position;
  logic [3:0] target;
  logic       busy;
  logic [3:0] dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  bit both_seen = 0;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_UP   = 4'b0010;
  localparam logic [3:0] ST_DEAD = 4'b1000;

  window_shade_motor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wshade    (wshade),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .position  (position),
    .target    (target),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (motor_up === 1'b1 && motor_down === 1'b1) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic motor_sel(input bit up);
    return up ? motor_up : motor_down;
  endfunction

  task automatic wait_on(input bit up, input string tag);
    int n = 0;
    while (motor_sel(up) !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk(tag, 32'(motor_sel(up)), 32'd1);
  endtask

  task automatic wait_pos(input logic [3:0] p, input string tag);
    int n = 0;
    while (position !== p && n < 600) begin
      step(1);
      n++;
    end
    chk(tag, 32'(position), 32'(p));
  endtask

  task automatic measure(input bit up, output int len);
    len = 0;
    while (motor_sel(up) === 1'b1 && len < 1000) begin
      len++;
      step(1);
    end
  endtask

  initial begin
    int len;
    bit saw;
    rst_n  = 1'b0;
    enable = 1'b1;
    wshade = 4'd0;

    // 1: reset state held for 10 cycles
    step(10);
    chk("rst_motor_up", 32'(motor_up), 32'd0);
    chk("rst_motor_down", 32'(motor_down), 32'd0);
    chk("rst_position", 32'(position), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    step(6);
    chk("idle_target", 32'(target), 32'd0);

    // 3: 2-cycle glitch on wshade is rejected
    wshade = 4'd9;
    step(2);
    wshade = 4'd0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (motor_up === 1'b1 || motor_down === 1'b1 || target !== 4'd0) saw = 1'b1;
    end
    chk("glitch_no_motion", 32'(saw), 32'd0);
    chk("glitch_target", 32'(target), 32'd0);

    // 2: 0 -> 3, filter latency and 48-cycle drive
    wshade = 4'd3;
    step(3);
    chk("filter_3_edges", 32'(target), 32'd0);
    step(1);
    chk("filter_4_edges", 32'(target), 32'd3);
    chk("decide_cycle_off", 32'(motor_up), 32'd0);
    step(1);
    chk("up_start", 32'(motor_up), 32'd1);
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_state", 32'(dbg_state), 32'(ST_UP));
    len = 0;
    while (motor_up === 1'b1 && len < 1000) begin
      len++;
      if (len == 17) chk("pos_after_16", 32'(position), 32'd1);
      if (len == 33) chk("pos_after_32", 32'(position), 32'd2);
      step(1);
    end
    chk("up3_len", 32'(len), 32'd48);
    chk("up3_pos", 32'(position), 32'd3);
    chk("up3_busy", 32'(busy), 32'd0);

    // 4: reversal mid-step goes through dead time
    wshade = 4'd12;
    wait_on(1'b1, "rev_up_start");
    wait_pos(4'd5, "rev_reach5");
    step(5);
    wshade = 4'd2;
    wait_pos(4'd6, "rev_step_done");
    chk("dead0_up", 32'(motor_up), 32'd0);
    chk("dead0_down", 32'(motor_down), 32'd0);
    chk("dead0_state", 32'(dbg_state), 32'(ST_DEAD));
    step(1);
    chk("dead1_state", 32'(dbg_state), 32'(ST_DEAD));
    chk("dead1_down", 32'(motor_down), 32'd0);
    step(1);
    chk("post_dead_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_dead_down", 32'(motor_down), 32'd0);
    step(1);
    chk("down_start", 32'(motor_down), 32'd1);
    measure(1'b0, len);
    chk("down_len", 32'(len), 32'd64);
    chk("down_pos", 32'(position), 32'd2);
    chk("down_target", 32'(target), 32'd2);

    // 5: enable=0 mid-step stops at the boundary, then resumes
    wshade = 4'd8;
    wait_pos(4'd4, "en_reach4");
    step(3);
    enable = 1'b0;
    len = 0;
    while (motor_up === 1'b1 && len < 100) begin
      len++;
      step(1);
    end
    chk("en_stop_pos", 32'(position), 32'd5);
    chk("en_stop_busy", 32'(busy), 32'd0);
    step(10);
    chk("en_frozen_pos", 32'(position), 32'd5);
    chk("en_frozen_motor", 32'(motor_up), 32'd0);
    chk("en_frozen_state", 32'(dbg_state), 32'(ST_IDLE));
    enable = 1'b1;
    step(1);
    chk("en_resume", 32'(motor_up), 32'd1);
    measure(1'b1, len);
    chk("en_resume_len", 32'(len), 32'd48);
    chk("en_resume_pos", 32'(position), 32'd8);

    // 6: reset during a DOWN step
    wshade = 4'd0;
    wait_pos(4'd7, "rst_reach7");
    step(4);
    chk("pre_rst_down", 32'(motor_down), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_down", 32'(motor_down), 32'd0);
    chk("rst_mid_up", 32'(motor_up), 32'd0);
    chk("rst_mid_pos", 32'(position), 32'd0);
    chk("rst_mid_target", 32'(target), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    wshade = 4'd7;
    @(negedge clk);
    rst_n = 1'b1;
    wait_on(1'b1, "rehome_start");
    measure(1'b1, len);
    chk("rehome_len", 32'(len), 32'd112);
    chk("rehome_pos", 32'(position), 32'd7);
    chk("rehome_target", 32'(target), 32'd7);

    chk("motors_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
